// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_pkg
// Description : Shared constants for the push-button conditioner: FSM state
//               encoding and the default 1 ms debounce interval at 12 MHz.
// Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

   // Default debounce interval: 1 ms at a 12 MHz system clock.
   localparam int DEBOUNCE_1MS_12MHZ = 12000;

   // Explicit 2-bit state encoding for the debounce FSM.
   localparam int          STATE_W        = 2;
   localparam logic [1:0]  S_LOW_ENC      = 2'd0;
   localparam logic [1:0]  S_CHK_HIGH_ENC = 2'd1;
   localparam logic [1:0]  S_HIGH_ENC     = 2'd2;
   localparam logic [1:0]  S_CHK_LOW_ENC  = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      S_LOW      = S_LOW_ENC,
      S_CHK_HIGH = S_CHK_HIGH_ENC,
      S_HIGH     = S_HIGH_ENC,
      S_CHK_LOW  = S_CHK_LOW_ENC
   } state_t;

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/button_sync.sv
`default_nettype none
// ============================================================================
// Module      : button_sync
// Description : Multi-flop metastability synchroniser for an asynchronous pin.
//               The only place in the fabric where the raw pin is sampled.
//               SYNC_STAGES legal range is 2..4.
// Revision    : 1.0 - initial release
// ============================================================================
module button_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the asynchronous pin through the flop chain; bit 0 samples the pin.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain_q[SYNC_STAGES-1];

endmodule : button_sync
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises and debounces a raw push-button pin, producing a
//               clean level plus one-cycle rise/fall pulses. A new level is
//               accepted only after DEBOUNCE_CYCLES consecutive stable cycles
//               on the synchronised input.
//               Optional macro BUTTON_CONDITIONER_TOGGLE_EN builds a toggle
//               register that flips on every accepted press; otherwise the
//               toggle port is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_12MHZ
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;

   button_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (sync)
   );

   // State, qualification counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state logic: a CHK state must see the candidate level on every
   // cycle until the counter reaches its last value, otherwise it falls back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (sync) begin
               state_d = S_CHK_HIGH;
               cnt_d   = '0;
            end
         end
         S_CHK_HIGH: begin
            if (!sync) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HIGH: begin
            if (!sync) begin
               state_d = S_CHK_LOW;
               cnt_d   = '0;
            end
         end
         S_CHK_LOW: begin
            if (sync) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

`ifdef BUTTON_CONDITIONER_TOGGLE_EN
   logic toggle_q;

   // Flip on the same edge that the rise pulse is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         toggle_q <= 1'b0;
      end else if (rise_d) begin
         toggle_q <= ~toggle_q;
      end
   end

   assign toggle = toggle_q;
`else
   assign toggle = 1'b0;
`endif

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. DUT0 uses a
//               4-cycle debounce, DUT1 the minimum of 1 cycle. Directed
//               vector table, hand-written corner sequences, then random
//               stimulus against a streak-counting reference model.
//               Honors BUTTON_CONDITIONER_TOGGLE_EN for toggle expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

   localparam int SS  = 2;
   localparam int DC0 = 4;
   localparam int DC1 = 1;
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
   localparam logic TOG_EN = 1'b1;
`else
   localparam logic TOG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, btn0, btn1;
   logic level0, rise0, fall0, toggle0;
   logic level1, rise1, fall1, toggle1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   button_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC0)) u_dut0 (
      .clk (clk), .rst (rst), .btn_in (btn0),
      .level (level0), .rise (rise0), .fall (fall0), .toggle (toggle0)
   );

   button_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC1)) u_dut1 (
      .clk (clk), .rst (rst), .btn_in (btn1),
      .level (level1), .rise (rise1), .fall (fall1), .toggle (toggle1)
   );

   // Reference model: the pin is delayed SS edges, then the level flips once
   // the delayed value has disagreed with it on dc+1 consecutive edges.
   typedef struct {
      logic [3:0] pipe;
      int         run;
      logic       level;
      logic       rise;
      logic       fall;
      logic       toggle;
   } model_t;

   model_t m0, m1;

   function automatic model_t model_step(model_t s, logic r, logic b, int dc);
      model_t n;
      n      = s;
      n.rise = 1'b0;
      n.fall = 1'b0;
      if (r) begin
         n.pipe   = '0;
         n.run    = 0;
         n.level  = 1'b0;
         n.toggle = 1'b0;
      end else begin
         n.run = (s.pipe[SS-1] != s.level) ? s.run + 1 : 0;
         if (n.run == dc + 1) begin
            n.level = ~s.level;
            n.rise  = n.level;
            n.fall  = ~n.level;
            n.run   = 0;
            if (n.rise && TOG_EN) n.toggle = ~s.toggle;
         end
         n.pipe = {s.pipe[2:0], b};
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m0 <= model_step(m0, rst, btn0, DC0);
      m1 <= model_step(m1, rst, btn1, DC1);
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic r;
      logic b;
      logic lv;
      logic ri;
      logic fa;
      logic tg;
   } vec_t;

   vec_t tbl[$];

   function automatic void push(logic r, logic b, logic lv, logic ri, logic fa, logic tg);
      vec_t v;
      v.r = r; v.b = b; v.lv = lv; v.ri = ri; v.fa = fa; v.tg = tg;
      tbl.push_back(v);
   endfunction

   // Watchdog so the bench can never hang.
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int h0, h1;
      logic [1:0] bounce;

      // ---------------- directed vector table (DUT0) ----------------
      push(1, 0, 0, 0, 0, 0);
      push(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) push(0, 1, 0, 0, 0, 0);   // press edges 1..6
      push(0, 1, 1, 1, 0, 1);                                 // edge 7
      push(0, 1, 1, 0, 0, 1);                                 // edge 8
      push(0, 1, 1, 0, 0, 1);
      push(0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 6; i++) push(0, 0, 1, 0, 0, 1);   // release edges 1..6
      push(0, 0, 0, 0, 1, 1);                                 // edge 7
      push(0, 0, 0, 0, 0, 1);
      bounce = 2'b00;
      for (int i = 0; i < 14; i++) begin                      // 3 high, 1 low, 2 high, low
         bounce[0] = (i < 3) || (i == 4) || (i == 5);
         push(0, bounce[0], 0, 0, 0, 1);
      end

      btn1 = 1'b0;
      foreach (tbl[i]) begin
         rst  = tbl[i].r;
         btn0 = tbl[i].b;
         step();
         chk($sformatf("tbl[%0d].level", i), level0, tbl[i].lv);
         chk($sformatf("tbl[%0d].rise", i), rise0, tbl[i].ri);
         chk($sformatf("tbl[%0d].fall", i), fall0, tbl[i].fa);
         chk($sformatf("tbl[%0d].toggle", i), toggle0, tbl[i].tg & TOG_EN);
      end

      // ---------------- reset during qualification (DUT0) ----------------
      rst = 1'b1; btn0 = 1'b0; step();
      rst = 1'b0;
      btn0 = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         rst = (e == 5);
         step();
         chk($sformatf("rstq.e%0d.level", e), level0, e >= 12);
         chk($sformatf("rstq.e%0d.rise", e), rise0, e == 12);
         chk($sformatf("rstq.e%0d.fall", e), fall0, 1'b0);
      end
      chk("rstq.toggle", toggle0, TOG_EN);
      btn0 = 1'b0;
      repeat (8) step();
      chk("rstq.released", level0, 1'b0);

      // ---------------- three press/release cycles: toggle ----------------
      rst = 1'b1; step();
      rst = 1'b0;
      chk("tog.reset", toggle0, 1'b0);
      for (int p = 0; p < 3; p++) begin
         btn0 = 1'b1;
         for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) chk($sformatf("tog.p%0d.before", p), toggle0, (p % 2 == 1) & TOG_EN);
            if (e == 7) chk($sformatf("tog.p%0d.after", p), toggle0, (p % 2 == 0) & TOG_EN);
         end
         btn0 = 1'b0;
         for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) chk($sformatf("tog.p%0d.fall", p), fall0, 1'b1);
         end
      end

      // ---------------- minimum debounce (DUT1) ----------------
      rst = 1'b1; step();
      rst = 1'b0;
      btn1 = 1'b1; step();
      btn1 = 1'b0;
      for (int e = 2; e <= 7; e++) begin
         step();
         chk($sformatf("min.glitch.e%0d.level", e), level1, 1'b0);
         chk($sformatf("min.glitch.e%0d.rise", e), rise1, 1'b0);
      end
      btn1 = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk($sformatf("min.step.e%0d.level", e), level1, e >= 4);
         chk($sformatf("min.step.e%0d.rise", e), rise1, e == 4);
      end
      btn1 = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk($sformatf("min.rel.e%0d.level", e), level1, e < 4);
         chk($sformatf("min.rel.e%0d.fall", e), fall1, e == 4);
      end

      // ---------------- random stimulus vs reference model ----------------
      h0 = 0;
      h1 = 0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd.dut0.level", level0, m0.level);
         chk("rnd.dut0.rise", rise0, m0.rise);
         chk("rnd.dut0.fall", fall0, m0.fall);
         chk("rnd.dut0.toggle", toggle0, m0.toggle);
         chk("rnd.dut1.level", level1, m1.level);
         chk("rnd.dut1.rise", rise1, m1.rise);
         chk("rnd.dut1.fall", fall1, m1.fall);
         chk("rnd.dut1.toggle", toggle1, m1.toggle);
         rst = ($urandom_range(0, 299) == 0);
         if (h0 == 0) begin btn0 = ~btn0; h0 = $urandom_range(1, 9); end else h0--;
         if (h1 == 0) begin btn1 = ~btn1; h1 = $urandom_range(1, 4); end else h1--;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_button_conditioner
`default_nettype wire
